// File: rtl/wheel_encoder_apb.sv
// APB3 slave: two x4 quadrature decoders giving 32-bit position and windowed velocity.
// Latency: pin change reaches pos 2 edges after it is sampled; vel updates once per SAMPLE_PERIOD.
// Backpressure: none, PREADY tied high, every transfer completes in setup + access.
module wheel_encoder_apb #(
  parameter int SAMPLE_PERIOD = 100000
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic [31:0] PRDATA,
  input  logic        enc1_a,
  input  logic        enc1_b,
  input  logic        enc2_a,
  input  logic        enc2_b,
  output logic        enc_err
);
  localparam int CW = $clog2(SAMPLE_PERIOD);
  localparam logic [CW-1:0] WIN_LAST = CW'(SAMPLE_PERIOD - 1);

  logic [1:0]    pin     [2];
  logic [1:0]    sync1   [2];
  logic [1:0]    sync2   [2];
  logic [1:0]    prev    [2];
  logic [31:0]   pos     [2];
  logic [31:0]   pos_nxt [2];
  logic [31:0]   snap    [2];
  logic [31:0]   vel     [2];
  logic [1:0]    err;
  logic [1:0]    err_nxt;
  logic [1:0]    ill;
  logic [1:0]    pos_clr;
  logic [1:0]    err_w1c;
  logic [CW-1:0] win_cnt;
  logic          win_end;
  logic          wr_en;
  logic [2:0]    idx;
  logic          unused_bits;

  assign pin[0]      = {enc1_a, enc1_b};
  assign pin[1]      = {enc2_a, enc2_b};
  assign idx         = PADDR[4:2];
  assign wr_en       = PSEL & PENABLE & PWRITE;
  assign pos_clr     = (wr_en && idx == 3'd5) ? PWDATA[1:0] : 2'b00;
  assign err_w1c     = (wr_en && idx == 3'd4) ? PWDATA[1:0] : 2'b00;
  assign win_end     = (win_cnt == WIN_LAST);
  assign PREADY      = 1'b1;
  assign PSLVERR     = 1'b0;
  assign unused_bits = ^{PADDR[31:5], PADDR[1:0], PWDATA[31:2]};

  // Forward (A leads) successor of a quadrature state: 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic [1:0] fwd_of(input logic [1:0] s);
    case (s)
      2'b00:   fwd_of = 2'b10;
      2'b10:   fwd_of = 2'b11;
      2'b11:   fwd_of = 2'b01;
      default: fwd_of = 2'b00;
    endcase
  endfunction

  always_comb begin
    ill = 2'b00;
    for (int c = 0; c < 2; c++) begin
      ill[c]     = ((prev[c] ^ sync2[c]) == 2'b11);
      pos_nxt[c] = pos[c];
      if (pos_clr[c])
        pos_nxt[c] = 32'd0;
      else if (sync2[c] == fwd_of(prev[c]))
        pos_nxt[c] = pos[c] + 32'd1;
      else if (prev[c] == fwd_of(sync2[c]))
        pos_nxt[c] = pos[c] - 32'd1;
    end
    // A fresh illegal step outranks a same-cycle clear
    err_nxt = (err & ~err_w1c) | ill;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESERN) begin
      for (int c = 0; c < 2; c++) begin
        sync1[c] <= 2'b00;
        sync2[c] <= 2'b00;
        prev[c]  <= 2'b00;
        pos[c]   <= 32'd0;
        snap[c]  <= 32'd0;
        vel[c]   <= 32'd0;
      end
      err     <= 2'b00;
      enc_err <= 1'b0;
      win_cnt <= '0;
    end else begin
      win_cnt <= win_end ? '0 : win_cnt + 1'b1;
      err     <= err_nxt;
      enc_err <= |err_nxt;
      for (int c = 0; c < 2; c++) begin
        sync1[c] <= pin[c];
        sync2[c] <= sync1[c];
        prev[c]  <= sync2[c];
        pos[c]   <= pos_nxt[c];
        // vel uses the pre-clear snapshot so a clear on the terminal edge reports 0 - snap
        if (win_end) begin
          vel[c]  <= pos_nxt[c] - snap[c];
          snap[c] <= pos_nxt[c];
        end else if (pos_clr[c]) begin
          snap[c] <= 32'd0;
        end
      end
    end
  end

  always_comb begin
    PRDATA = 32'd0;
    if (PSEL) begin
      case (idx)
        3'd0:    PRDATA = pos[0];
        3'd1:    PRDATA = pos[1];
        3'd2:    PRDATA = vel[0];
        3'd3:    PRDATA = vel[1];
        3'd4:    PRDATA = {30'd0, err};
        default: PRDATA = 32'd0;
      endcase
    end
  end
endmodule

// File: tb/tb_wheel_encoder_apb.sv
// Bench for wheel_encoder_apb: randomized encoder steps checked against an event-list model
// (each step is a timestamped +1/-1 whose effect lands 3 edges after it is driven).
module tb_wheel_encoder_apb;
  localparam int SP = 1000;

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        PSEL = 1'b0;
  logic        PENABLE = 1'b0;
  logic        PWRITE = 1'b0;
  logic [31:0] PADDR = 32'd0;
  logic [31:0] PWDATA = 32'd0;
  logic        PREADY;
  logic        PSLVERR;
  logic [31:0] PRDATA;
  logic        enc1_a = 1'b0;
  logic        enc1_b = 1'b0;
  logic        enc2_a = 1'b0;
  logic        enc2_b = 1'b0;
  logic        enc_err;

  wheel_encoder_apb #(.SAMPLE_PERIOD(SP)) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PSLVERR(PSLVERR), .PRDATA(PRDATA),
    .enc1_a(enc1_a), .enc1_b(enc1_b), .enc2_a(enc2_a), .enc2_b(enc2_b), .enc_err(enc_err)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct { int ch; int eff; int d; } ev_t;
  ev_t evq[$];
  int  rst_edge = 0;
  int  clr_edge [2];
  int  qidx [2];
  int  n_checks = 0;
  int  n_fail = 0;

  function automatic logic [1:0] gray(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b10;
      2:       return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic logic [31:0] model_pos(input int ch, input int upto);
    int s = 0;
    foreach (evq[i])
      if (evq[i].ch == ch && evq[i].eff > rst_edge && evq[i].eff > clr_edge[ch] && evq[i].eff <= upto)
        s += evq[i].d;
    return 32'(s);
  endfunction

  function automatic logic [31:0] model_vel(input int ch, input int k);
    int s = 0;
    foreach (evq[i])
      if (evq[i].ch == ch && evq[i].eff > rst_edge + (k - 1) * SP && evq[i].eff <= rst_edge + k * SP)
        s += evq[i].d;
    return 32'(s);
  endfunction

  task automatic set_pins(input int ch, input logic [1:0] v);
    if (ch == 0) {enc1_a, enc1_b} = v;
    else         {enc2_a, enc2_b} = v;
  endtask

  // Moves the pins of one channel; dir 2 is an illegal both-bits change worth 0 counts
  task automatic drive_step(input int ch, input int dir);
    qidx[ch] = (qidx[ch] + dir + 4) % 4;
    set_pins(ch, gray(qidx[ch]));
    evq.push_back('{ch, cyc + 3, (dir == 2) ? 0 : dir});
  endtask

  task automatic step(input int ch, input int dir, input int gap);
    @(posedge PCLK); #1;
    drive_step(ch, dir);
    repeat (gap - 1) @(posedge PCLK);
  endtask

  task automatic do_reset(input int n);
    @(posedge PCLK); #1;
    PRESERN = 1'b0;
    set_pins(0, 2'b00);
    set_pins(1, 2'b00);
    qidx[0] = 0;
    qidx[1] = 0;
    repeat (n) @(posedge PCLK);
    #1;
    PRESERN = 1'b1;
    rst_edge = cyc;
    clr_edge[0] = cyc;
    clr_edge[1] = cyc;
    evq.delete();
  endtask

  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data, output int rc);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    data = PRDATA;
    rc = cyc;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data, output int wedge);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    wedge = cyc + 1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // Pin step timed so its count lands on the same edge as the write
  task automatic step_with_write(input int ch, input int dir, input logic [31:0] addr,
                                 input logic [31:0] data, output int wedge);
    @(posedge PCLK); #1;
    drive_step(ch, dir);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = data;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    wedge = cyc + 1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  // Single-cycle combinational read, called at a negedge
  task automatic peek(input logic [31:0] addr, output logic [31:0] data);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
    #1;
    data = PRDATA;
    PSEL = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int rc;
    do_reset(3);
    for (int a = 0; a < 8; a++) begin
      apb_read(32'(a * 4), d, rc);
      n_checks++;
      if (d !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_reg_%0h: got %h expected 00000000", a * 4, d);
      end
    end
    @(negedge PCLK);
    n_checks++;
    if (enc_err !== 1'b0 || PRDATA !== 32'd0 || PREADY !== 1'b1 || PSLVERR !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: enc_err=%b PRDATA=%h PREADY=%b PSLVERR=%b expected 0,0,1,0",
               enc_err, PRDATA, PREADY, PSLVERR);
    end
  endtask

  task automatic test_forward();
    logic [31:0] d;
    int rc;
    for (int i = 0; i < 100; i++) step(0, 1, $urandom_range(4, 8));
    apb_read(32'h00, d, rc);
    n_checks++;
    if (d !== 32'd100) begin
      n_fail++;
      $display("FAIL fwd_pos1: got %0d expected 100", d);
    end
    for (int i = 0; i < 30; i++) step(0, -1, $urandom_range(4, 8));
    apb_read(32'h00, d, rc);
    n_checks++;
    if (d !== 32'd70) begin
      n_fail++;
      $display("FAIL rev_pos1: got %0d expected 70", d);
    end
    apb_read(32'h04, d, rc);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL fwd_pos2: got %0d expected 0", d);
    end
  endtask

  task automatic test_random_walk();
    logic [31:0] d;
    int rc;
    for (int i = 0; i < 60; i++)
      step($urandom_range(0, 1), ($urandom_range(0, 1) == 1) ? 1 : -1, $urandom_range(1, 6));
    for (int ch = 0; ch < 2; ch++) begin
      apb_read(32'(ch * 4), d, rc);
      n_checks++;
      if (d !== model_pos(ch, rc)) begin
        n_fail++;
        $display("FAIL walk_pos%0d: got %h expected %h", ch + 1, d, model_pos(ch, rc));
      end
    end
  endtask

  task automatic test_velocity();
    do_reset(1);
    fork
      begin
        for (int i = 0; i < 60; i++) step(1, -1, 50);
      end
      begin
        logic [31:0] v;
        for (int k = 1; k <= 3; k++) begin
          while (cyc < rst_edge + k * SP) @(negedge PCLK);
          peek(32'h0C, v);
          n_checks++;
          if (v !== model_vel(1, k)) begin
            n_fail++;
            $display("FAIL vel2_window%0d: got %h expected %h", k, v, model_vel(1, k));
          end
          if (k >= 2) begin
            n_checks++;
            if (v !== 32'hFFFFFFEC) begin
              n_fail++;
              $display("FAIL vel2_const_window%0d: got %h expected ffffffec", k, v);
            end
          end
        end
      end
    join
  endtask

  task automatic test_illegal_w1c();
    logic [31:0] d;
    int rc;
    int w;
    step(0, 2, 4);
    apb_read(32'h00, d, rc);
    n_checks++;
    if (d !== model_pos(0, rc)) begin
      n_fail++;
      $display("FAIL illegal_pos1: got %h expected %h", d, model_pos(0, rc));
    end
    apb_read(32'h10, d, rc);
    n_checks++;
    if (d !== 32'h1 || enc_err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_status: status=%h enc_err=%b expected 1,1", d, enc_err);
    end
    apb_write(32'h10, 32'h1, w);
    apb_read(32'h10, d, rc);
    n_checks++;
    if (d !== 32'h0 || enc_err !== 1'b0) begin
      n_fail++;
      $display("FAIL w1c_status: status=%h enc_err=%b expected 0,0", d, enc_err);
    end
    step_with_write(0, 2, 32'h10, 32'h1, w);
    apb_read(32'h10, d, rc);
    n_checks++;
    if (d !== 32'h1 || enc_err !== 1'b1) begin
      n_fail++;
      $display("FAIL w1c_vs_set: status=%h enc_err=%b expected 1,1", d, enc_err);
    end
    apb_write(32'h10, 32'h3, w);
    apb_read(32'h10, d, rc);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++;
      $display("FAIL w1c_final: got %h expected 0", d);
    end
  endtask

  task automatic test_wrap_clear();
    logic [31:0] d;
    int rc;
    int w;
    apb_write(32'h14, 32'h1, w);
    clr_edge[0] = w;
    apb_read(32'h00, d, rc);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL clear_pos1: got %h expected 0", d);
    end
    step(0, -1, 4);
    apb_read(32'h00, d, rc);
    n_checks++;
    if (d !== 32'hFFFFFFFF) begin
      n_fail++;
      $display("FAIL wrap_pos1: got %h expected ffffffff", d);
    end
    step_with_write(0, 1, 32'h14, 32'h1, w);
    clr_edge[0] = w;
    apb_read(32'h00, d, rc);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL clear_vs_count: got %h expected 0", d);
    end
    apb_read(32'h04, d, rc);
    n_checks++;
    if (d !== model_pos(1, rc)) begin
      n_fail++;
      $display("FAIL clear_pos2_untouched: got %h expected %h", d, model_pos(1, rc));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int rc;
    int w;
    apb_write(32'h14, 32'h1, w);
    clr_edge[0] = w;
    for (int i = 0; i < 37; i++) step(0, 1, 4);
    apb_read(32'h00, d, rc);
    n_checks++;
    if (d !== 32'd37) begin
      n_fail++;
      $display("FAIL mid_pos1_pre: got %0d expected 37", d);
    end
    do begin
      @(posedge PCLK); #1;
    end while (((cyc - rst_edge) % SP) != 499);
    do_reset(1);
    apb_read(32'h00, d, rc);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_pos1_post: got %h expected 0", d);
    end
    apb_read(32'h08, d, rc);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_vel1_post: got %h expected 0", d);
    end
    for (int i = 0; i < 5; i++) step(0, 1, 10);
    while (cyc < rst_edge + SP - 1) @(negedge PCLK);
    peek(32'h08, d);
    n_checks++;
    if (d !== 32'd0) begin
      n_fail++;
      $display("FAIL mid_vel1_early: got %h expected 0", d);
    end
    @(negedge PCLK);
    peek(32'h08, d);
    n_checks++;
    if (d !== model_vel(0, 1) || d !== 32'd5) begin
      n_fail++;
      $display("FAIL mid_vel1_update: got %h expected %h", d, model_vel(0, 1));
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    qidx[0] = 0;
    qidx[1] = 0;
    clr_edge[0] = 0;
    clr_edge[1] = 0;
    test_reset();
    test_forward();
    test_random_walk();
    test_velocity();
    test_illegal_w1c();
    test_wrap_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
